// File: rtl/lfsr_prbs_checker_pkg.sv
// rtl/lfsr_prbs_checker_pkg.sv - shared constants and types for the 4-bit LFSR random stream
package lfsr_prbs_checker_pkg;

    localparam int LFSR_W = 4;
    localparam int TAP_A  = 3;
    localparam int TAP_B  = 4;
    localparam int PERIOD = 15;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // hist[0] is the newest bit, so tap k lives at hist[k-1]
    function automatic logic lfsr_tap(input logic [LFSR_W-1:0] hist);
        return hist[TAP_A-1] ^ hist[TAP_B-1];
    endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// rtl/lfsr_predictor.sv - four-bit history of the random stream and its next-bit prediction
module lfsr_predictor
    import lfsr_prbs_checker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              shift_in,
    output logic              pred,
    output logic [LFSR_W-1:0] hist
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {hist[LFSR_W-2:0], shift_in};
        end
    end

    assign pred = lfsr_tap(hist);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// rtl/lfsr_prbs_checker.sv - self-synchronising checker for the 4-bit LFSR random stream
module lfsr_prbs_checker
    import lfsr_prbs_checker_pkg::*;
#(
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_ERRS = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_ERRS + 1);
    localparam logic [MW-1:0]    LOCK_V   = MW'(LOCK_CNT);
    localparam logic [BW-1:0]    LOSS_V   = BW'(LOSS_ERRS);
    localparam logic [3:0]       WIN_LAST = 4'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q;
    logic [2:0]          fill_cnt;
    logic [MW-1:0]       match_cnt;
    logic [3:0]          win_cnt;
    logic [BW-1:0]       bad_cnt;
    logic                pred;
    logic [LFSR_W-1:0]   hist;
    logic                shift_en;
    logic                shift_in;
    logic                mismatch;
    logic                err_hit;
    logic [MW-1:0]       match_inc;
    logic [BW-1:0]       bad_inc;

    assign shift_en  = din_valid && (state_q == SEED || state_q == ACQ || state_q == LOCKED);
    // Once locked the history free-runs on its own prediction so a corrupted bit never re-enters it
    assign shift_in  = (state_q == LOCKED) ? pred : din;
    assign mismatch  = din ^ pred;
    assign err_hit   = din_valid && (state_q == LOCKED) && mismatch;
    assign match_inc = match_cnt + MW'(1);
    assign bad_inc   = bad_cnt + BW'(err_hit);
    assign state     = state_q;

    lfsr_predictor u_predictor (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .shift_in (shift_in),
        .pred     (pred),
        .hist     (hist)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            err_count <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            bad_cnt   <= '0;
        end else begin
            bit_err <= err_hit;

            if (clear_cnt) begin
                err_count <= '0;
            end else if (err_hit && err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end

            case (state_q)
                SEED: begin
                    if (din_valid) begin
                        fill_cnt <= fill_cnt + 3'd1;
                        if (fill_cnt == 3'd3) begin
                            state_q   <= ACQ;
                            match_cnt <= '0;
                        end
                    end
                end
                ACQ: begin
                    if (din_valid) begin
                        // An all-zero history predicts zero forever, so it never earns credit
                        if (hist == '0 || mismatch) begin
                            match_cnt <= '0;
                        end else if (match_inc >= LOCK_V) begin
                            match_cnt <= '0;
                            state_q   <= LOCKED;
                            locked    <= 1'b1;
                            win_cnt   <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (din_valid) begin
                        win_cnt <= (win_cnt == WIN_LAST) ? 4'd0 : win_cnt + 4'd1;
                        if (bad_inc >= LOSS_V) begin
                            state_q  <= SEED;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            // The wrapping bit still belongs to the old window
                            bad_cnt <= (win_cnt == WIN_LAST) ? '0 : bad_inc;
                        end
                    end
                end
                default: begin
                    state_q  <= SEED;
                    locked   <= 1'b0;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb/tb_lfsr_prbs_checker.sv - directed self-checking bench for lfsr_prbs_checker
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked, bit_err, locked2, bit_err2;
    logic [15:0] err_count;
    logic [1:0]  err_count2;
    logic [1:0]  state, state2;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int stray = 0;

    // Seed 1000 stream, one full period
    bit pat [0:14] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};

    always #5 clk = ~clk;

    lfsr_prbs_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count),
        .state     (state)
    );

    lfsr_prbs_checker #(.LOCK_CNT(8), .LOSS_ERRS(7), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked2),
        .bit_err   (bit_err2),
        .err_count (err_count2),
        .state     (state2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_raw(input bit b, input bit v, input bit clr);
        din = b;
        din_valid = v;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        if (bit_err) pulses++;
    endtask

    task automatic send(input int idx, input bit flip, input bit clr);
        send_raw(pat[idx % 15] ^ flip, 1'b1, clr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        clear_cnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
    endtask

    initial begin
        #3;
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_bit_err", 32'(bit_err), 0);
        check_eq("rst_err_count", 32'(err_count), 0);

        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(i, 1'b0, 1'b0);
            if (i == 10) check_eq("seed_not_locked_11", 32'(locked), 0);
            if (i == 11) begin
                check_eq("seed_locked_12", 32'(locked), 1);
                check_eq("seed_state_locked", 32'(state), 2);
            end
        end
        check_eq("seed_err_count", 32'(err_count), 0);
        check_eq("seed_pulses", 32'(pulses), 0);
        check_eq("seed_still_locked", 32'(locked), 1);

        do_reset();
        for (int i = 0; i < 60; i++) begin
            send(i, i == 40, 1'b0);
            if (i == 40) begin
                check_eq("flip_bit_err", 32'(bit_err), 1);
                check_eq("flip_err_count", 32'(err_count), 1);
            end
            if (i == 41) check_eq("flip_pulse_width", 32'(bit_err), 0);
        end
        check_eq("flip_pulses", 32'(pulses), 1);
        check_eq("flip_err_final", 32'(err_count), 1);
        check_eq("flip_locked", 32'(locked), 1);

        #3;
        reset = 1'b1;
        #1;
        check_eq("async_rst_locked", 32'(locked), 0);
        check_eq("async_rst_err", 32'(err_count), 0);
        check_eq("async_rst_state", 32'(state), 0);

        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(i, (i == 45) || (i == 47) || (i == 49), 1'b0);
            if (i == 48) check_eq("loss_before_3rd", 32'(locked), 1);
            if (i == 49) begin
                check_eq("loss_unlocked", 32'(locked), 0);
                check_eq("loss_bit_err", 32'(bit_err), 1);
                check_eq("loss_err_count", 32'(err_count), 3);
                check_eq("loss_state_seed", 32'(state), 0);
            end
            if (i == 60) check_eq("relock_not_yet", 32'(locked), 0);
            if (i == 61) check_eq("relock_after_12", 32'(locked), 1);
        end
        check_eq("loss_pulses", 32'(pulses), 3);
        check_eq("loss_err_final", 32'(err_count), 3);

        do_reset();
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            send_raw(1'b0, 1'b1, 1'b0);
            if (i >= 3 && state != 2'd1) stray++;
        end
        check_eq("zero_left_acq", 32'(stray), 0);
        check_eq("zero_state", 32'(state), 1);
        check_eq("zero_locked", 32'(locked), 0);
        check_eq("zero_err_count", 32'(err_count), 0);

        do_reset();
        begin
            int k;
            k = 0;
            for (int c = 0; c < 40; c++) begin
                if (c % 2 == 0) begin
                    send(k, 1'b0, 1'b0);
                    k++;
                end else begin
                    send_raw(1'b1, 1'b0, 1'b0);
                end
                if (c == 20) check_eq("gap_not_locked", 32'(locked), 0);
                if (c == 22) check_eq("gap_locked", 32'(locked), 1);
            end
        end
        check_eq("gap_pulses", 32'(pulses), 0);
        check_eq("gap_err_count", 32'(err_count), 0);

        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(i, (i == 20) || (i == 35) || (i == 50) || (i == 65) || (i == 80) || (i == 95),
                 i == 95);
            if (i == 80) begin
                check_eq("sat_err_count", 32'(err_count2), 3);
                check_eq("sat_locked", 32'(locked2), 1);
                check_eq("wide_err_count", 32'(err_count), 5);
                check_eq("spread_errs_locked", 32'(locked), 1);
            end
            if (i == 95) begin
                check_eq("clear_wins", 32'(err_count), 0);
                check_eq("clear_bit_err", 32'(bit_err), 1);
                check_eq("clear_locked", 32'(locked), 1);
            end
        end
        check_eq("sat_pulses", 32'(pulses), 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

- Receive-side counterpart of the 4-bit LFSR random-number generator.
- Consumes the generator's serial output bit-by-bit and self-synchronises a local copy of the LFSR to the stream.
- Declares lock, then flags and counts mismatching bits.
- Sits at the far end of the random-bit link, for link test and bring-up.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive correct predictions required to declare lock
- LOSS_ERRS, 3: errors within one 15-bit window that drop lock
- CNT_W, 16: width of the error counter

Ports (`clk` is the single clock; `reset` is asynchronous, active-high):
- clk  in  1  single clock
- reset  in  1  asynchronous reset, active-high
- din  in  1  received serial bit
- din_valid  in  1  din qualifier; bits are consumed only when high
- clear_cnt  in  1  synchronous clear of err_count
- locked  out  1  checker synchronised to stream
- bit_err  out  1  one-cycle pulse: last valid bit mismatched while locked
- err_count  out  CNT_W  saturating count of locked-mode mismatches
- state  out  2  current FSM state, for debug

## Operation
- **Stream law.** The generator emits b[t] = b[t-3] XOR b[t-4] (period 15 for any nonzero seed).
- **History register.** hist[3:0] holds the last four bits: hist[0] = newest, hist[3] = oldest.
- **Prediction.** pred = hist[2] XOR hist[3].
- **FSM states:** SEED=0, ACQ=1, LOCKED=2. State 3 is unused and recovers to SEED.
- **SEED**
  - Each valid bit shifts din into hist and increments fill_cnt.
  - After the 4th valid bit: go to ACQ with match_cnt=0.
- **ACQ**
  - Each valid bit shifts din (the received bit) into hist.
  - If hist is 0000 before the shift: no match credit and match_cnt=0. This handles an all-zero stream.
  - Otherwise, din==pred increments match_cnt; a mismatch clears match_cnt and the FSM stays in ACQ.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, clear win_cnt and bad_cnt.
- **LOCKED**
  - Each valid bit shifts pred (not din) into hist, so errors do not propagate.
  - win_cnt counts valid bits 0..14 and wraps to 0, clearing bad_cnt at the wrap.
  - On din!=pred: pulse bit_err, increment err_count, increment bad_cnt.
  - If bad_cnt would reach LOSS_ERRS: go to SEED, clear fill_cnt, and keep hist contents (they are overwritten during SEED).
- **Counter width and saturation.** err_count saturates at 2^CNT_W-1.
- **clear_cnt:**
  - Zeroes err_count on the next edge.
  - If clear_cnt and an error occur in the same cycle, the result is err_count=0; the clear wins.
  - Does not affect bit_err or lock.
- **din_valid low:** no state, counter or history change; bit_err is 0.

## Timing
- All outputs are registered.
- Reset values: state=SEED, locked=0, bit_err=0, err_count=0, hist=0000, and all internal counters 0.
- **bit_err:** high for exactly one cycle, on the cycle after the edge that samples the erroneous valid bit.
- **locked:** goes to 1 on the cycle after the edge that samples the LOCK_CNT-th correct valid bit.
- **Minimum lock latency:** 4 + LOCK_CNT valid bits, i.e. 12 at defaults.
- **Loss of lock:** locked goes to 0 on the cycle after the edge that samples the LOSS_ERRS-th error in a window. That error is still counted and pulsed.
- **Reset mid-operation:** asserting reset returns every register to its reset value immediately, independent of clk.
- **Throughput:** one bit per clk, with no back-pressure.

## Structure
- **Shared package** (same package the generator side uses):
  - State encoding constants SEED/ACQ/LOCKED.
  - LFSR width 4.
  - Tap positions (3,4).
  - Period constant 15.
- **Sub-module lfsr_predictor:**
  - Holds hist and computes pred.
  - Inputs: shift_en, shift_in.
  - Output: pred.
  - Reusable by any future receiver of the random stream.
- **Top level** holds the FSM, counters and outputs.

## Test plan
- **Seed 1000 with continuous valid:** the generator stream is 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1,… -> locked=1 after the 12th bit, err_count stays 0 for 100 bits.
- **Single flipped bit at bit 40 while locked:**
  - One bit_err pulse, err_count=1, locked stays 1.
  - No follow-on errors, confirming no error multiplication.
- **Three flipped bits within one 15-bit window:**
  - Three bit_err pulses, err_count=3.
  - locked=0 the cycle after the 3rd error.
  - Relock 12 bits later.
- **All-zero stream for 50 bits:** state never leaves ACQ, locked=0, err_count=0.
- **din_valid toggled 1-0-1 (50% duty):** lock after 12 valid bits (about 24 cycles); gaps produce no bit_err.
- **Boundary cases:**
  - reset asserted mid-LOCKED -> immediate locked=0, err_count=0.
  - Separately, CNT_W=2 with 5 errors -> err_count=3 (saturated).
  - clear_cnt coinciding with an error -> err_count=0.
